// File: rtl/param_serializer.sv
// Parallel-to-serial converter for the UART TX path with a one-word holding buffer.
// A new word can be accepted while the current one shifts, so frames can run back to back.
module param_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit PAR_ODD    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  data_ready_out,
  input  logic                  ser_en_in,
  output logic                  ser_busy_out,
  output logic                  data_out,
  output logic                  parity_out,
  output logic                  ser_done_out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [DATA_WIDTH-1:0] hold_r, hold_s;
  logic                  hold_full_r, hold_full_s;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_s;
  logic                  parity_r, parity_s;
  logic                  done_r, done_s;
  logic                  accept_s;
  logic                  final_s;

  function automatic logic word_parity(input logic [DATA_WIDTH-1:0] w);
    return (^w) ^ PAR_ODD;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[DATA_WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[DATA_WIDTH-1:1]};
    end
  endfunction

  assign accept_s = data_valid_in && !hold_full_r;
  assign final_s  = (state_r == SHIFT) && ser_en_in && (bit_cnt_r == LAST_BIT);

  // Next-state and datapath decode; final-bit priority is hold reg, then bypass, then idle.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    bit_cnt_s   = bit_cnt_r;
    parity_s    = parity_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_s   = data_in;
          parity_s  = word_parity(data_in);
          bit_cnt_s = '0;
          state_s   = SHIFT;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        if (final_s) begin
          done_s    = 1'b1;
          bit_cnt_s = '0;
          if (hold_full_r) begin
            shift_s     = hold_r;
            parity_s    = word_parity(hold_r);
            hold_full_s = 1'b0;
          end else if (accept_s) begin
            shift_s  = data_in;
            parity_s = word_parity(data_in);
          end else begin
            state_s = IDLE;
          end
        end else begin
          if (ser_en_in) begin
            shift_s   = shift_word(shift_r);
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
          if (accept_s) begin
            hold_s      = data_in;
            hold_full_s = 1'b1;
          end else begin
            hold_full_s = hold_full_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: shift/hold words, counter, parity and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r     <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      bit_cnt_r   <= '0;
      parity_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      bit_cnt_r   <= bit_cnt_s;
      parity_r    <= parity_s;
      done_r      <= done_s;
    end
  end

  assign data_ready_out = !hold_full_r;
  assign ser_busy_out   = (state_r == SHIFT);
  assign data_out       = (state_r == SHIFT) ?
                          (MSB_FIRST ? shift_r[DATA_WIDTH-1] : shift_r[0]) : 1'b0;
  assign parity_out     = parity_r;
  assign ser_done_out   = done_r;

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer: table-driven vectors for an LSB-first/even instance,
// plus hand-written sequences for gapped strobes, MSB-first/odd parity and mid-word reset.
module tb_param_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  logic       v1 = 1'b0, v2 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic       rdy1, busy1, dout1, par1, done1;
  logic       rdy2, busy2, dout2, par2, done2;

  int total = 0;
  int bad = 0;

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .PAR_ODD(1'b0)) dut1 (
    .clk(clk), .reset_n(rst_n), .data_in(d1), .data_valid_in(v1), .data_ready_out(rdy1),
    .ser_en_in(en1), .ser_busy_out(busy1), .data_out(dout1), .parity_out(par1),
    .ser_done_out(done1)
  );

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .PAR_ODD(1'b1)) dut2 (
    .clk(clk), .reset_n(rst_n), .data_in(d2), .data_valid_in(v2), .data_ready_out(rdy2),
    .ser_en_in(en2), .ser_busy_out(busy2), .data_out(dout2), .parity_out(par2),
    .ser_done_out(done2)
  );

  always #5 clk = ~clk;

  // Expected output packing: {ready, busy, data, parity, done}
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       en;
    logic [4:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic logic [4:0] outs1();
    return {rdy1, busy1, dout1, par1, done1};
  endfunction

  function automatic logic [4:0] outs2();
    return {rdy2, busy2, dout2, par2, done2};
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic en, input logic [4:0] e);
    vt.push_back('{v, d, en, e});
  endtask

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {rdy,busy,dout,par,done}=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] w07 = 8'h07;
  logic [7:0] w55 = 8'h55;
  int         msb81 [8] = '{1, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    // LSB first, 0xA5, strobe held high; strobe in IDLE is ignored
    add(1'b1, 8'hA5, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b10001);
    add(1'b0, 8'h00, 1'b0, 5'b10000);
    add(1'b0, 8'h00, 1'b1, 5'b10000);
    add(1'b0, 8'h00, 1'b0, 5'b10000);
    // back-to-back: 0x0F then 0xF0 offered while bit 2 is on the line
    add(1'b1, 8'h0F, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b1, 8'hF0, 1'b1, 5'b01100);
    add(1'b0, 8'h00, 1'b1, 5'b01000);
    add(1'b0, 8'h00, 1'b1, 5'b01000);
    add(1'b0, 8'h00, 1'b1, 5'b01000);
    add(1'b0, 8'h00, 1'b1, 5'b01000);
    add(1'b0, 8'h00, 1'b1, 5'b11001);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b10001);
    add(1'b0, 8'h00, 1'b0, 5'b10000);
    // bypass on the final edge: 0xFF then 0x3C offered exactly on its last strobe
    add(1'b1, 8'hFF, 1'b1, 5'b11100);
    for (int i = 0; i < 7; i++) add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b1, 8'h3C, 1'b1, 5'b11001);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11100);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b11000);
    add(1'b0, 8'h00, 1'b1, 5'b10001);
    add(1'b0, 8'h00, 1'b0, 5'b10000);

    #12;
    chk("reset1", outs1(), 5'b10000);
    chk("reset2", outs2(), 5'b10000);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      v1 = vt[i].v; d1 = vt[i].d; en1 = vt[i].en;
      cyc();
      chk($sformatf("vec%0d", i), outs1(), vt[i].exp);
    end
    v1 = 1'b0; en1 = 1'b0;

    // Gapped strobe, one in four cycles, word 0x07 (odd count of ones -> parity 1)
    en1 = 1'b1;
    repeat (3) begin cyc(); chk("idle_en", outs1(), 5'b10000); end
    en1 = 1'b0; v1 = 1'b1; d1 = 8'h07;
    cyc();
    v1 = 1'b0;
    chk("gap_load", outs1(), 5'b11110);
    for (int k = 0; k < 8; k++) begin
      repeat (3) begin
        cyc();
        chk($sformatf("gap_hold%0d", k), outs1(), {1'b1, 1'b1, w07[k], 1'b1, 1'b0});
      end
      en1 = 1'b1;
      cyc();
      en1 = 1'b0;
      if (k < 7) chk($sformatf("gap_step%0d", k), outs1(), {1'b1, 1'b1, w07[k+1], 1'b1, 1'b0});
      else       chk("gap_done", outs1(), 5'b10011);
    end
    cyc();
    chk("gap_after", outs1(), 5'b10010);

    // MSB first, odd parity, word 0x81
    v2 = 1'b1; d2 = 8'h81; en2 = 1'b1;
    cyc();
    v2 = 1'b0;
    chk("msb_b0", outs2(), 5'b11110);
    for (int k = 1; k < 8; k++) begin
      cyc();
      chk($sformatf("msb_b%0d", k), outs2(), {1'b1, 1'b1, msb81[k] != 0, 1'b1, 1'b0});
    end
    cyc();
    chk("msb_done", outs2(), 5'b10011);
    en2 = 1'b0;
    cyc();
    chk("msb_idle", outs2(), 5'b10010);

    // Reset mid-word with the hold buffer full (0x31 shifting, 0xC3 held)
    v1 = 1'b1; d1 = 8'h31; en1 = 1'b1;
    cyc();
    d1 = 8'hC3;
    cyc();
    v1 = 1'b0;
    chk("rst_hold", outs1(), 5'b01010);
    cyc();
    cyc();
    chk("rst_pre", outs1(), 5'b01010);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async1", outs1(), 5'b10000);
    chk("rst_async2", outs2(), 5'b10000);
    cyc();
    chk("rst_held", outs1(), 5'b10000);
    #2 rst_n = 1'b1;
    cyc();
    chk("rst_noresume", outs1(), 5'b10000);
    v1 = 1'b1; d1 = 8'h55;
    cyc();
    v1 = 1'b0;
    chk("post_b0", outs1(), 5'b11100);
    for (int k = 1; k < 8; k++) begin
      cyc();
      chk($sformatf("post_b%0d", k), outs1(), {1'b1, 1'b1, w55[k], 1'b0, 1'b0});
    end
    cyc();
    chk("post_done", outs1(), 5'b10001);
    en1 = 1'b0;
    cyc();
    chk("post_idle", outs1(), 5'b10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
